imem_loader: RTL

- Instruction-memory responder that sits on the other side of the fetch stage's instruction read.
- Owns the 32-bit instruction store. Fills it from a byte-serial program-load stream, replacing file-based preload.
- Serves word-aligned fetch reads with 1-cycle registered latency.
- Asserts busy, wired to the fetch stage's hazard/stall input, while a load is in progress.

---
 rtl/imem_loader_if.sv | 37 +++
 rtl/imem_loader.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_if
// Purpose  : Program-load stream and fetch-read bundle for imem_loader.
// Revision : 1.0
// ============================================================================
interface imem_loader_if #(
    parameter int AW = 10
);
    logic          ld_start;
    logic          ld_valid;
    logic [7:0]    ld_byte;
    logic          ld_last;
    logic          ld_ready;
    logic          ld_done;
    logic [AW:0]   word_count;
    logic          busy;
    logic          fetch_valid;
    logic [31:0]   fetch_addr;
    logic [31:0]   instruction;
    logic          inst_valid;
    logic          addr_err;
    logic          ovf_err;

    modport master (
        output ld_start, ld_valid, ld_byte, ld_last, fetch_valid, fetch_addr,
        input  ld_ready, ld_done, word_count, busy, instruction, inst_valid,
               addr_err, ovf_err
    );

    modport slave (
        input  ld_start, ld_valid, ld_byte, ld_last, fetch_valid, fetch_addr,
        output ld_ready, ld_done, word_count, busy, instruction, inst_valid,
               addr_err, ovf_err
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Instruction store filled from a byte-serial load stream and read
//            by the fetch stage with one cycle of registered latency.
// Revision : 1.0
// ============================================================================
module imem_loader #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  wire logic   clk,
    input  wire logic   rst,
    imem_loader_if.slave bus
);

    localparam logic [1:0]  c_IDLE  = 2'd0;
    localparam logic [1:0]  c_LOAD  = 2'd1;
    localparam logic [1:0]  c_READY = 2'd2;
    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    logic [1:0]   state_q, state_d;
    logic [AW:0]  wptr_q, wptr_d;
    logic [1:0]   bidx_q, bidx_d;
    logic [31:0]  asm_q, asm_d;
    logic         done_q, done_d;
    logic         ovf_q, ovf_d;
    logic [31:0]  instr_q, instr_d;
    logic         ivalid_q, ivalid_d;
    logic         aerr_q, aerr_d;

    logic [31:0]  mem_q [DEPTH];

    logic         w_busy;
    logic         w_ld_ready;
    logic [AW:0]  w_base_wptr;
    logic [1:0]   w_base_bidx;
    logic [31:0]  w_base_asm;
    logic [31:0]  w_word;
    logic         w_accept;
    logic         w_complete;
    logic         w_room;
    logic         w_we;
    logic         w_addr_bad;
    logic [AW-1:0] w_raddr;
    logic [31:0]  w_rdata;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // LOAD lingers for the ld_done cycle so busy drops one cycle after it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  if (bus.ld_start) state_d = c_LOAD;
            c_LOAD: begin
                if (bus.ld_start)  state_d = c_LOAD;
                else if (done_q)   state_d = c_READY;
            end
            c_READY: if (bus.ld_start) state_d = c_LOAD;
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        w_busy     = 1'b1;
        w_ld_ready = 1'b0;
        case (state_q)
            c_LOAD:  w_ld_ready = !done_q;
            c_READY: w_busy     = 1'b0;
            default: ;
        endcase
    end

    // ------------------------------------------------------- load datapath
    // A start request zeroes the pointers before the same-cycle byte lands.
    assign w_base_wptr = bus.ld_start ? '0    : wptr_q;
    assign w_base_bidx = bus.ld_start ? 2'd0  : bidx_q;
    assign w_base_asm  = bus.ld_start ? 32'd0 : asm_q;

    assign w_accept   = w_ld_ready && bus.ld_valid;
    assign w_word     = w_base_asm | ({bus.ld_byte, 24'd0} >> {w_base_bidx, 3'b000});
    assign w_complete = w_accept && ((w_base_bidx == 2'd3) || bus.ld_last);
    assign w_room     = (w_base_wptr < c_DEPTH);
    assign w_we       = w_complete && w_room;

    always_comb begin
        wptr_d = w_we ? (w_base_wptr + (AW+1)'(1)) : w_base_wptr;
        bidx_d = w_base_bidx;
        asm_d  = w_base_asm;
        if (w_accept) begin
            if (w_complete) begin
                bidx_d = 2'd0;
                asm_d  = 32'd0;
            end else begin
                bidx_d = w_base_bidx + 2'd1;
                asm_d  = w_word;
            end
        end
        done_d = w_accept && bus.ld_last;
        ovf_d  = (bus.ld_start ? 1'b0 : ovf_q) | (w_complete && !w_room);
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            mem_q[w_base_wptr[AW-1:0]] <= w_word;
        end
    end

    // -------------------------------------------------------- fetch path
    assign w_raddr    = bus.fetch_addr[AW+1:2];
    assign w_rdata    = mem_q[w_raddr];
    assign w_addr_bad = (bus.fetch_addr[1:0] != 2'b00)
                     || (bus.fetch_addr[31:AW+2] != '0)
                     || ({1'b0, w_raddr} >= c_DEPTH);

    always_comb begin
        ivalid_d = 1'b0;
        aerr_d   = 1'b0;
        instr_d  = instr_q;
        if (state_q != c_READY) begin
            instr_d = 32'd0;
        end else if (bus.fetch_valid) begin
            ivalid_d = 1'b1;
            aerr_d   = w_addr_bad;
            instr_d  = w_addr_bad ? 32'd0 : w_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q   <= '0;
            bidx_q   <= 2'd0;
            asm_q    <= 32'd0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            instr_q  <= 32'd0;
            ivalid_q <= 1'b0;
            aerr_q   <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            bidx_q   <= bidx_d;
            asm_q    <= asm_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            instr_q  <= instr_d;
            ivalid_q <= ivalid_d;
            aerr_q   <= aerr_d;
        end
    end

    // Write pointer doubles as the word count; it saturates at DEPTH.
    assign bus.ld_ready    = w_ld_ready;
    assign bus.ld_done     = done_q;
    assign bus.word_count  = wptr_q;
    assign bus.busy        = w_busy;
    assign bus.instruction = instr_q;
    assign bus.inst_valid  = ivalid_q;
    assign bus.addr_err    = aerr_q;
    assign bus.ovf_err     = ovf_q;

endmodule
`default_nettype wire
